seq_det_frame_ctrl: RTL and testbench

//   Sequencing controller for the bit-serial 1011 detector datapath. Accepts parallel

---
 rtl/seq_det_frame_ctrl.sv | 148 ++++++++++++++
 tb/tb_seq_det_frame_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_frame_ctrl.sv
// ---------------------------------------------------------------------------
// seq_det_frame_ctrl
//   Word-level sequencer wrapped around an overlapping 1011 Mealy detector.
//   A word taken over the in_valid/in_ready handshake is scanned MSB-first at
//   one bit per clock. The number of 1011 matches in that word is then offered
//   on the cnt_valid/cnt_ready handshake.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    word to scan, MSB first
//   in_valid   in_data valid
//   in_ready   controller can accept a word (IDLE only)
//   cnt_data   match count of the last word
//   cnt_valid  cnt_data valid, held until cnt_ready
//   cnt_ready  consumer takes cnt_data
//   match      one-cycle pulse per detected 1011 (one cycle after the bit)
//   busy       high while scanning or reporting
// ---------------------------------------------------------------------------
module seq_det_frame_ctrl #(
    parameter int unsigned W     = 8,
    parameter bit          CARRY = 1'b0,
    parameter int unsigned CW    = $clog2(W / 3 + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [W-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [CW-1:0] cnt_data,
    output logic          cnt_valid,
    input  logic          cnt_ready,
    output logic          match,
    output logic          busy
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        D_S0 = 2'd0,
        D_S1 = 2'd1,
        D_S2 = 2'd2,
        D_S3 = 2'd3
    } det_t;

    state_t         r_state;
    det_t           r_det;
    logic [W-1:0]   r_shreg;
    logic [IW-1:0]  r_idx;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_cnt_data;
    logic           r_cnt_valid;
    logic           r_in_ready;
    logic           r_match;
    logic           r_busy;

    logic           w_bit;
    logic           w_hit;
    det_t           w_det_next;
    logic [CW-1:0]  w_cnt_next;

    // Detector next state for the bit currently being scanned
    always_comb begin
        w_bit      = r_shreg[r_idx];
        w_hit      = 1'b0;
        w_det_next = r_det;
        case (r_det)
            D_S0: w_det_next = w_bit ? D_S1 : D_S0;
            D_S1: w_det_next = w_bit ? D_S1 : D_S2;
            D_S2: w_det_next = w_bit ? D_S3 : D_S0;
            D_S3: begin
                w_det_next = w_bit ? D_S1 : D_S2;
                w_hit      = w_bit;
            end
            default: w_det_next = D_S0;
        endcase
        w_cnt_next = r_cnt + CW'(w_hit);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_det       <= D_S0;
            r_shreg     <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_cnt_data  <= '0;
            r_cnt_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_match <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_shreg    <= in_data;
                        r_idx      <= LAST_IDX;
                        r_cnt      <= '0;
                        // CARRY keeps a partial 1011 alive across words
                        if (!CARRY) begin
                            r_det <= D_S0;
                        end
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_det   <= w_det_next;
                    r_match <= w_hit;
                    r_cnt   <= w_cnt_next;
                    r_idx   <= r_idx - IW'(1);
                    // Last bit: the count includes this bit's hit
                    if (r_idx == '0) begin
                        r_cnt_data  <= w_cnt_next;
                        r_cnt_valid <= 1'b1;
                        r_state     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (cnt_ready) begin
                        r_cnt_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign cnt_data  = r_cnt_data;
    assign cnt_valid = r_cnt_valid;
    assign match     = r_match;
    assign busy      = r_busy;

endmodule

// File: tb/tb_seq_det_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_det_frame_ctrl
//   Drives a CARRY=0 and a CARRY=1 instance with the same words. Expected
//   counts are queued at word acceptance and compared on each count handshake.
// ---------------------------------------------------------------------------
module tb_seq_det_frame_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = $clog2(W / 3 + 2);

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          cnt_ready;

    logic          in_ready0, cnt_valid0, match0, busy0;
    logic [CW-1:0] cnt_data0;
    logic          in_ready1, cnt_valid1, match1, busy1;
    logic [CW-1:0] cnt_data1;

    int n_checks = 0;
    int n_fail   = 0;
    int q0[$];
    int q1[$];
    int match_cnt0 = 0;
    int exp_match0 = 0;
    int cyc_cnt    = 0;
    int acc_cyc    = 0;
    bit rand_bp    = 1'b0;

    // Reference for the CARRY=1 instance: bit history carried across words
    logic [3:0] m_h   = 4'd0;
    int         m_len = 0;

    seq_det_frame_ctrl #(.W(W), .CARRY(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .cnt_data(cnt_data0), .cnt_valid(cnt_valid0),
        .cnt_ready(cnt_ready), .match(match0), .busy(busy0)
    );

    seq_det_frame_ctrl #(.W(W), .CARRY(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .cnt_data(cnt_data1), .cnt_valid(cnt_valid1),
        .cnt_ready(cnt_ready), .match(match1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Count overlapping 1011 in a word: fresh history (c0) and carried history (c1)
    task automatic model_word(input logic [W-1:0] w, output int c0, output int c1);
        logic [3:0] h;
        int         len;
        h   = 4'd0;
        len = 0;
        c0  = 0;
        c1  = 0;
        for (int i = W - 1; i >= 0; i--) begin
            h = {h[2:0], w[i]};
            len++;
            if (len >= 4 && h == 4'b1011) c0++;
            m_h = {m_h[2:0], w[i]};
            m_len++;
            if (m_len >= 4 && m_h == 4'b1011) c1++;
        end
    endtask

    // Scoreboard: pop and compare on every count handshake
    always @(negedge clk) begin
        int e;
        #1;
        if (!reset) begin
            if (match0) match_cnt0++;
            if (cnt_valid0 && cnt_ready) begin
                if (q0.size() == 0) begin
                    check("sb_empty0", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    check("sb_cnt0", 32'(cnt_data0), 32'(e));
                end
                check("sb_vld1", 32'(cnt_valid1), 32'd1);
                if (q1.size() == 0) begin
                    check("sb_empty1", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    check("sb_cnt1", 32'(cnt_data1), 32'(e));
                end
            end
        end
    end

    // Offer a word; e0/e1 < 0 take the model's expectation
    task automatic send_word(input logic [W-1:0] w, input int e0, input int e1);
        int c0, c1, n;
        in_data  = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready0 && n < 200) begin
            @(negedge clk);
            if (rand_bp) cnt_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("accept_timeout", 32'(in_ready0), 32'd1);
        acc_cyc = cyc_cnt;
        model_word(w, c0, c1);
        @(posedge clk);
        q0.push_back(e0 < 0 ? c0 : e0);
        q1.push_back(e1 < 0 ? c1 : e1);
        exp_match0 += (e0 < 0 ? c0 : e0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || cnt_valid0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q0.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready0),  32'd1);
        check({tag, "_cnt_valid"}, 32'(cnt_valid0), 32'd0);
        check({tag, "_busy"},      32'(busy0),      32'd0);
        check({tag, "_match"},     32'(match0),     32'd0);
        check({tag, "_cnt_data"},  32'(cnt_data0),  32'd0);
        check({tag, "_in_ready1"}, 32'(in_ready1),  32'd1);
        check({tag, "_busy1"},     32'(busy1),      32'd0);
    endtask

    // Drop expectations of a discarded word and restart the carried history
    task automatic flush_model();
        while (q0.size() != 0) exp_match0 -= q0.pop_front();
        q1.delete();
        m_h   = 4'd0;
        m_len = 0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        flush_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int cyc, snap, t_a, m_before;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        cnt_ready = 1'b1;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single match word, latency and match pulse
        m_before = match_cnt0;
        send_word(8'b1011_0000, 1, -1);
        cyc = 0;
        while (!cnt_valid0 && cyc < 40) begin
            check("busy_shift", 32'(busy0), 32'd1);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
        drain();
        check("match_pulses", 32'(match_cnt0 - m_before), 32'd1);

        // Reset pulse while idle
        repeat (3) @(negedge clk);
        do_reset("rst_idle");

        // Overlap and all-ones words, back to back for throughput
        send_word(8'b1011_0110, 2, -1);
        t_a = acc_cyc;
        send_word(8'b1111_1111, 0, -1);
        check("throughput", 32'(acc_cyc - t_a), 32'(W + 2));
        drain();

        // Word-boundary match: counted only with CARRY=1
        do_reset("rst_carry");
        send_word(8'b0000_0101, 0, 0);
        send_word(8'b1000_0000, 0, 1);
        drain();

        // Back-pressure in REPORT
        cnt_ready = 1'b0;
        send_word(8'b0101_1010, 1, -1);
        cyc = 0;
        while (!cnt_valid0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_valid", 32'(cnt_valid0), 32'd1);
        snap     = int'(cnt_data0);
        in_data  = 8'b0011_1100;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(cnt_valid0), 32'd1);
            check("bp_hold_data",  32'(cnt_data0),  32'(snap));
            check("bp_in_ready",   32'(in_ready0),  32'd0);
        end
        cnt_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 32'(in_ready0), 32'd1);
        send_word(8'b0011_1100, 0, -1);
        drain();

        // Reset in the 4th scan cycle discards the word
        send_word(8'b1011_1011, 2, -1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        flush_model();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send_word(8'b0001_0110, 1, 1);
        drain();

        // Random words with random back-pressure
        rand_bp = 1'b1;
        for (int i = 0; i < 24; i++) begin
            send_word(W'($urandom), -1, -1);
        end
        rand_bp   = 1'b0;
        cnt_ready = 1'b1;
        drain();
        repeat (4) @(negedge clk);
        check("match_total", 32'(match_cnt0), 32'(exp_match0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
